// File: rtl/pc_redirect_ctl.sv
// pc_redirect_ctl
// Funnels every control-flow redirect (trap/xret, jalr, branch mispredict,
// jal, fence.i) into the PC register. It picks one winner per cycle by fixed
// priority, parks stall-sensitive redirects until fetch is free, and runs the
// fence.i I-cache invalidate handshake before restarting fetch.
// All outputs are registered, so a request accepted at edge N shows up after edge N.
module pc_redirect_ctl #(
    parameter int XLEN        = 64,
    parameter int KILL_CYCLES = 2     // 1..7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            t_req,
    input  logic [XLEN-1:0] t_addr,
    input  logic            jalr_req,
    input  logic [XLEN-1:0] jalr_addr,
    input  logic            br_req,
    input  logic [XLEN-1:0] br_addr,
    input  logic            jal_req,
    input  logic [XLEN-1:0] jal_addr,
    input  logic            fi_req,
    input  logic [XLEN-1:0] fi_addr,
    input  logic            stall_if,
    input  logic            icache_inv_ack,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_addr,
    output logic            kill_if,
    output logic            icache_inv_req,
    output logic            fi_busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HOLD     = 2'd1;
    localparam logic [1:0] S_FI_INV   = 2'd2;
    localparam logic [1:0] S_FI_REDIR = 2'd3;

    logic [1:0]      state, state_n;
    logic [XLEN-1:0] pend_addr, pend_addr_n;
    logic            pend_is_br, pend_is_br_n;
    logic [2:0]      kill_cnt, kill_cnt_n;

    logic            issue;
    logic [XLEN-1:0] issue_addr;

    // Trap/xret and jalr are never held back; branch and jal respect stall_if.
    logic            hi_req, lo_req;
    logic [XLEN-1:0] hi_addr, lo_addr;
    logic [XLEN-1:0] eff_addr;
    logic            eff_br;

    // Collapse the five sources into the two priority classes.
    always_comb begin
        hi_req  = t_req | jalr_req;
        hi_addr = t_req ? t_addr : jalr_addr;
        lo_req  = br_req | jal_req;
        lo_addr = br_req ? br_addr : jal_addr;
    end

    // Next-state logic: choose the winner and decide whether it issues now.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n      = state;
        pend_addr_n  = pend_addr;
        pend_is_br_n = pend_is_br;
        issue        = 1'b0;
        issue_addr   = pend_addr;
        eff_addr     = pend_addr;
        eff_br       = pend_is_br;

        case (state)
            S_IDLE: begin
                if (hi_req) begin
                    issue      = 1'b1;
                    issue_addr = hi_addr;
                end else if (lo_req) begin
                    if (!stall_if) begin
                        issue      = 1'b1;
                        issue_addr = lo_addr;
                    end else begin
                        pend_addr_n  = lo_addr;
                        pend_is_br_n = br_req;
                        state_n      = S_HOLD;
                    end
                end else if (fi_req) begin
                    pend_addr_n = fi_addr;
                    state_n     = S_FI_INV;
                end
            end

            S_HOLD: begin
                if (hi_req) begin
                    issue      = 1'b1;
                    issue_addr = hi_addr;
                    state_n    = S_IDLE;
                end else begin
                    // An older branch supersedes a parked jal; anything else is younger.
                    if (br_req && !pend_is_br) begin
                        eff_addr = br_addr;
                        eff_br   = 1'b1;
                    end
                    if (!stall_if) begin
                        issue      = 1'b1;
                        issue_addr = eff_addr;
                        state_n    = S_IDLE;
                    end else begin
                        pend_addr_n  = eff_addr;
                        pend_is_br_n = eff_br;
                    end
                end
            end

            S_FI_INV: begin
                if (hi_req) begin
                    pend_addr_n = hi_addr;
                end
                if (icache_inv_ack) begin
                    issue      = 1'b1;
                    issue_addr = hi_req ? hi_addr : pend_addr;
                    state_n    = S_FI_REDIR;
                end
            end

            S_FI_REDIR: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Every issued redirect reloads the front-end kill window.
        if (issue) begin
            kill_cnt_n = 3'(KILL_CYCLES);
        end else if (kill_cnt != 3'd0) begin
            kill_cnt_n = kill_cnt - 3'd1;
        end else begin
            kill_cnt_n = 3'd0;
        end
    end

    // State and registered outputs; reset also drops icache_inv_req at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pend_addr      <= '0;
            pend_is_br     <= 1'b0;
            kill_cnt       <= 3'd0;
            redir_valid    <= 1'b0;
            redir_addr     <= '0;
            kill_if        <= 1'b0;
            icache_inv_req <= 1'b0;
            fi_busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state          <= state_n;
            pend_addr      <= pend_addr_n;
            pend_is_br     <= pend_is_br_n;
            kill_cnt       <= kill_cnt_n;
            redir_valid    <= issue;
            if (issue) begin
                redir_addr <= {issue_addr[XLEN-1:1], 1'b0};
            end
            kill_if        <= (kill_cnt_n != 3'd0) || (state_n == S_FI_INV);
            icache_inv_req <= (state_n == S_FI_INV);
            fi_busy        <= (state_n == S_FI_INV);
        end
    end

endmodule

// File: doc/pc_redirect_ctl.md
Name: pc_redirect_ctl

Overview:
- Sequences every control-flow redirect into the program counter register. Sources are trap, jalr, branch-mispredict and jal redirects, plus the fence.i flush.
- Arbitrates simultaneous requests by fixed priority. Holds stall-sensitive redirects until the fetch stage is free.
- Runs the fence.i I-cache invalidate handshake before restarting fetch.
- Sits between execute/commit and the PC register. Drives its redirect inputs and the front-end kill.

Parameters:
XLEN, 64, address width.
KILL_CYCLES, 2, cycles kill_if stays asserted per redirect (1..7).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
t_req  in  1  trap/xret redirect request
t_addr  in  XLEN  trap target
jalr_req  in  1  jalr redirect request
jalr_addr  in  XLEN  jalr target
br_req  in  1  branch mispredict request
br_addr  in  XLEN  corrected branch target
jal_req  in  1  jal redirect request
jal_addr  in  XLEN  jal target
fi_req  in  1  fence.i reached execute (single-cycle pulse)
fi_addr  in  XLEN  address following fence.i
stall_if  in  1  fetch stage stalled
icache_inv_ack  in  1  I-cache invalidate complete (one-cycle pulse)
redir_valid  out  1  redirect PC this cycle
redir_addr  out  XLEN  redirect target
kill_if  out  1  flush IF/ID contents
icache_inv_req  out  1  I-cache invalidate request (level)
fi_busy  out  1  fence.i in progress; hold upstream issue

Behaviour:
- Reset (async, rst_n=0): state IDLE; redir_valid=0, redir_addr=0, kill_if=0, icache_inv_req=0, fi_busy=0; pending and kill counter cleared.
- All outputs are registered. A request accepted at edge N is visible after edge N (1-cycle latency).
- Priority: t > jalr > br > jal > fi. Only the winner is acted on each cycle; losers are dropped, since they are younger and get flushed.
- States: IDLE, HOLD, FI_INV, FI_REDIR.
- IDLE, t/jalr: issue the redirect regardless of stall_if. redir_valid=1 for exactly 1 cycle.
- IDLE, br/jal with stall_if=0: issue immediately.
- IDLE, br/jal with stall_if=1: latch address, go to HOLD.
- HOLD: when stall_if=0, issue the pending redirect and return to IDLE.
  - A new t/jalr in HOLD overrides pending and issues at once (→IDLE).
  - A new br in HOLD replaces a pending jal. Any other new request in HOLD is ignored.
- IDLE, fi_req winner: latch fi_addr, go to FI_INV. icache_inv_req=1 and fi_busy=1 from the next cycle.
- FI_INV: hold icache_inv_req until icache_inv_ack is sampled 1, then go to FI_REDIR and drop icache_inv_req.
  - t/jalr arriving in FI_INV replaces the latched address. No redirect issues until the invalidate completes.
  - br/jal in FI_INV are ignored.
- FI_REDIR: redir_valid=1 with the latched address for 1 cycle, ignoring stall_if. fi_busy deasserts the same cycle. Return to IDLE.
- kill_if: asserted starting the cycle redir_valid=1, for KILL_CYCLES consecutive cycles.
  - A new redirect during kill reloads the counter.
  - kill_if is also 1 throughout FI_INV.
- redir_addr holds its last value when redir_valid=0. Bit 0 is forced to 0 on every load.
- redir_valid is never high for 2 consecutive cycles unless a new higher-or-equal request arrives.
- icache_inv_ack outside FI_INV is ignored.
- Reset mid-FI_INV aborts the handshake immediately: icache_inv_req drops asynchronously.

Test Plan:
- br_req=1 with br_addr=0x8000_0100, stall_if=0 → next cycle redir_valid=1, redir_addr=0x8000_0100; kill_if=1 for 2 cycles.
- t_req, jalr_req, br_req all 1 in the same cycle (t_addr=0x8000_0000) → single redirect to 0x8000_0000; no second redir_valid.
- jal_req (0x1040) with stall_if=1 for 3 cycles → no redir_valid while stalled; redir_valid with 0x1040 the cycle after stall_if falls.
  - Repeat with t_req (0x200) in the second stall cycle → redirect to 0x200 only.
- fi_req (fi_addr=0x2004), icache_inv_ack after 5 cycles → icache_inv_req=1 and fi_busy=1 for 5 cycles; then redir_valid with 0x2004 for 1 cycle; fi_busy falls the same cycle.
- fi_req, then t_req (0x300) during FI_INV → no redirect until ack; then redirect to 0x300.
- rst_n pulled low during FI_INV → all outputs 0 immediately; after release state is IDLE and a late icache_inv_ack is ignored.
